// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, load-use stall, branch flush, LSU wait
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idu_index_rs1,
    input  logic [4:0]       idu_index_rs2,
    input  logic             idu_rs1_used,
    input  logic             idu_rs2_used,
    input  logic [4:0]       exu_index_rd,
    input  logic             exu_wb_en,
    input  logic             exu_load_en,
    input  logic             exu_jump_en,
    input  logic             exu_branch_en,
    input  logic             exu_branch_result,
    input  logic [4:0]       lsu_index_rd,
    input  logic             lsu_wb_en,
    input  logic             lsu_busy,
    output logic             stall,
    output logic             flush_nop,
    output logic             redirect,
    output logic             fw_en1,
    output logic             fw_en2,
    output logic             fw_sel1,
    output logic             fw_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {ST_RUN, ST_LU, ST_FLUSH, ST_MWAIT} state_t;

    state_t     state, state_nx;
    logic [3:0] fcnt, fcnt_nx;
    logic       taken, load_use;
    logic       hit_e1, hit_e2, hit_l1, hit_l2;
    logic       stall_c, flush_c, redirect_c;

    assign taken  = exu_jump_en | (exu_branch_en & exu_branch_result);
    assign hit_e1 = exu_wb_en & (exu_index_rd != 5'd0) & (exu_index_rd == idu_index_rs1);
    assign hit_e2 = exu_wb_en & (exu_index_rd != 5'd0) & (exu_index_rd == idu_index_rs2);
    assign hit_l1 = lsu_wb_en & (lsu_index_rd != 5'd0) & (lsu_index_rd == idu_index_rs1);
    assign hit_l2 = lsu_wb_en & (lsu_index_rd != 5'd0) & (lsu_index_rd == idu_index_rs2);
    assign load_use = exu_load_en & ((idu_rs1_used & hit_e1) | (idu_rs2_used & hit_e2));

    always_comb begin
        state_nx   = state;
        fcnt_nx    = fcnt;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        redirect_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (lsu_busy) begin
                    stall_c  = 1'b1;
                    state_nx = ST_MWAIT;
                end else if (taken) begin
                    redirect_c = 1'b1;
                    flush_c    = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_nx = ST_RUN;
                    end else begin
                        fcnt_nx  = 4'(FLUSH_CYCLES - 2);
                        state_nx = ST_FLUSH;
                    end
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    flush_c  = 1'b1;
                    state_nx = ST_LU;
                end
            end
            ST_LU: begin
                // Load has moved to LSU; only a busy memory can still hold us.
                if (lsu_busy) begin
                    stall_c  = 1'b1;
                    state_nx = ST_MWAIT;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                if (fcnt == 4'd0) state_nx = ST_RUN;
                else              fcnt_nx  = fcnt - 4'd1;
            end
            ST_MWAIT: begin
                if (lsu_busy) stall_c  = 1'b1;
                else          state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    assign stall     = ~rst & stall_c;
    assign flush_nop = ~rst & flush_c;
    assign redirect  = ~rst & redirect_c;

    // An EXU hit always shadows LSU; an EXU load hit is left to the load-use stall.
    assign fw_en1  = ~rst & idu_rs1_used & ((hit_e1 & ~exu_load_en) | (~hit_e1 & hit_l1));
    assign fw_en2  = ~rst & idu_rs2_used & ((hit_e2 & ~exu_load_en) | (~hit_e2 & hit_l2));
    assign fw_sel1 = ~rst & idu_rs1_used & ~hit_e1 & hit_l1;
    assign fw_sel2 = ~rst & idu_rs2_used & ~hit_e2 & hit_l2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            fcnt      <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            fcnt      <= fcnt_nx;
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, flush_nop};
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  idu_index_rs1, idu_index_rs2, exu_index_rd, lsu_index_rd;
    logic        idu_rs1_used, idu_rs2_used;
    logic        exu_wb_en, exu_load_en, exu_jump_en, exu_branch_en, exu_branch_result;
    logic        lsu_wb_en, lsu_busy;
    logic        stall, flush_nop, redirect, fw_en1, fw_en2, fw_sel1, fw_sel2;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2),
        .idu_rs1_used(idu_rs1_used), .idu_rs2_used(idu_rs2_used),
        .exu_index_rd(exu_index_rd), .exu_wb_en(exu_wb_en), .exu_load_en(exu_load_en),
        .exu_jump_en(exu_jump_en), .exu_branch_en(exu_branch_en),
        .exu_branch_result(exu_branch_result),
        .lsu_index_rd(lsu_index_rd), .lsu_wb_en(lsu_wb_en), .lsu_busy(lsu_busy),
        .stall(stall), .flush_nop(flush_nop), .redirect(redirect),
        .fw_en1(fw_en1), .fw_en2(fw_en2), .fw_sel1(fw_sel1), .fw_sel2(fw_sel2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {stall, flush_nop, redirect, fw_en1, fw_sel1, fw_en2, fw_sel2}
    typedef struct {
        logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] erd; logic ewb; logic eld; logic ej; logic eb; logic ebr;
        logic [4:0] lrd; logic lwb; logic busy;
        logic [6:0] ctl; int sc; int fc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] erd, input logic ewb,
                                input logic eld, input logic ej, input logic eb, input logic ebr,
                                input logic [4:0] lrd, input logic lwb, input logic busy,
                                input logic [6:0] ctl, input int sc, input int fc);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.erd = erd; v.ewb = ewb; v.eld = eld; v.ej = ej; v.eb = eb; v.ebr = ebr;
        v.lrd = lrd; v.lwb = lwb; v.busy = busy;
        v.ctl = ctl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        idu_index_rs1 = v.rs1; idu_rs1_used = v.u1;
        idu_index_rs2 = v.rs2; idu_rs2_used = v.u2;
        exu_index_rd = v.erd; exu_wb_en = v.ewb; exu_load_en = v.eld;
        exu_jump_en = v.ej; exu_branch_en = v.eb; exu_branch_result = v.ebr;
        lsu_index_rd = v.lrd; lsu_wb_en = v.lwb; lsu_busy = v.busy;
    endtask

    task automatic check(input string name, input logic [6:0] ctl, input int sc, input int fc);
        logic [6:0] got;
        got = {stall, flush_nop, redirect, fw_en1, fw_sel1, fw_en2, fw_sel2};
        n_vec++;
        if (got !== ctl || stall_cnt !== 32'(sc) || flush_cnt !== 32'(fc)) begin
            n_bad++;
            $display("FAIL %s: ctl=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b stall_cnt=%0d flush_cnt=%0d",
                     name, got, stall_cnt, flush_cnt, ctl, sc, fc);
        end
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0,0, 0,0,0,0,0,0, 0,0,0, 7'b0000000, 0,0);
        //         rs1 u1 rs2 u2 erd ewb eld ej eb ebr lrd lwb busy  ctl         sc fc
        vecs.push_back(mk(5,1, 0,1,  5,1,0,0,0,0,  0,0,0, 7'b0001000, 0,0)); // EXU forward
        vecs.push_back(mk(0,0, 3,1,  0,0,0,0,0,0,  3,1,0, 7'b0000011, 0,0)); // LSU forward
        vecs.push_back(mk(4,1, 0,0,  4,1,0,0,0,0,  4,1,0, 7'b0001000, 0,0)); // EXU shadows LSU
        vecs.push_back(mk(6,0, 0,0,  6,1,0,0,0,0,  0,0,0, 7'b0000000, 0,0)); // operand unused
        vecs.push_back(mk(0,1, 0,0,  0,1,1,0,0,0,  0,0,0, 7'b0000000, 0,0)); // x0 load, no stall
        vecs.push_back(mk(0,0, 7,1,  7,1,1,0,0,0,  0,0,0, 7'b1100000, 0,0)); // load-use
        vecs.push_back(mk(0,0, 7,1,  0,0,0,0,0,0,  7,1,0, 7'b0000011, 1,1)); // LU: fwd from LSU
        vecs.push_back(mk(8,1, 0,0,  8,1,1,0,1,1,  0,0,0, 7'b0110000, 1,1)); // taken beats load-use
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,1, 7'b0100000, 1,2)); // FLUSH ignores taken/busy
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,0,0,  0,0,0, 7'b0000000, 1,3));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,1,0,  0,0,0, 7'b0000000, 1,3)); // not taken
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,1, 7'b1000000, 1,3)); // busy beats taken
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,1, 7'b1000000, 2,3));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,1, 7'b1000000, 3,3));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,1, 7'b1000000, 4,3));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,0, 7'b0000000, 5,3)); // MWAIT release
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,0, 7'b0110000, 5,3)); // redirect in RUN
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,0,0,  0,0,0, 7'b0100000, 5,4));
        vecs.push_back(mk(9,1,10,1,  9,1,1,0,0,0, 10,1,0, 7'b1100011, 5,5)); // load-use + LSU fwd
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,0,0,  0,0,1, 7'b1000000, 6,6)); // LU sees busy
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,0,0,  0,0,0, 7'b0000000, 7,6));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,0,0,0,  0,0,0, 7'b0000000, 7,6));
        vecs.push_back(mk(0,0, 0,0,  0,0,0,1,0,0,  0,0,0, 7'b0110000, 7,6)); // enter FLUSH

        // Reset: drive a forwarding hit and a taken jump, all outputs must stay low.
        apply(mk(5,1, 5,1, 5,1,0,1,0,0, 0,0,1, 7'b0, 0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 7'b0000000, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].sc, vecs[i].fc);
            @(posedge clk);
            #1;
        end

        // Now in FLUSH: second bubble, then reset mid-sequence.
        apply(idle);
        @(negedge clk);
        check("flush_second", 7'b0100000, 7, 7);
        #1 rst = 1'b1;
        #1 check("rst_async", 7'b0000000, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_run", 7'b0000000, 0, 0);
        @(posedge clk);
        #1 apply(mk(0,0, 7,1, 7,1,1,0,0,0, 0,0,0, 7'b0, 0,0));
        @(negedge clk);
        check("post_rst_loaduse", 7'b1100000, 0, 0);
        @(posedge clk);
        #1 apply(idle);
        @(negedge clk);
        check("post_rst_lu", 7'b0000000, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. Watches the IDU source registers against in-flight EXU/LSU destinations and the EXU branch/jump outcome. Drives forwarding selects, IFU/IDU stall, and the EXU `flush_nop` bubble. Sequences multi-cycle control-flow flushes and exposes stall/flush event counters for perf reporting.

## Interface
- `FLUSH_CYCLES`, default 2: number of consecutive bubble cycles injected into EXU on a taken branch/jump; legal range 1..15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `idu_index_rs1`, `idu_index_rs2`  in  5  IDU source register indices.
- `idu_rs1_used`, `idu_rs2_used`  in  1  the IDU instruction reads rs1/rs2.
- `exu_index_rd`  in  5  destination of the instruction now in the EXU output register.
- `exu_wb_en`, `exu_load_en`  in  1  that instruction writes back / is a load.
- `exu_jump_en`, `exu_branch_en`, `exu_branch_result`  in  1  control-flow outcome of that instruction.
- `lsu_index_rd`  in  5  destination of the instruction in the LSU output register.
- `lsu_wb_en`  in  1  that instruction writes back.
- `lsu_busy`  in  1  LSU memory access not complete.
- `stall`  out  1  hold PC, IFU and IDU registers.
- `flush_nop`  out  1  EXU latches a bubble.
- `redirect`  out  1  IFU loads `exu_branch_pc` (one-cycle pulse).
- `fw_en1`, `fw_en2`  out  1  forward into ALU operand 1/2.
- `fw_sel1`, `fw_sel2`  out  1  forward source: 0 = EXU result, 1 = LSU result.
- `stall_cnt`, `flush_cnt`  out  `CNT_W`  cycles with stall=1 / flush_nop=1.

## Operation
- Definitions:
  - `taken = exu_jump_en | (exu_branch_en & exu_branch_result)`.
  - `hitE(rs) = exu_wb_en & exu_index_rd!=0 & exu_index_rd==rs`.
  - `hitL(rs) = lsu_wb_en & lsu_index_rd!=0 & lsu_index_rd==rs`.
  - `load_use = exu_load_en & ((rs1_used & hitE(rs1)) | (rs2_used & hitE(rs2)))`.
- Forwarding (combinational, any state): for each operand, with `used` the matching `idu_rsN_used`:
  - If `used & hitE & !exu_load_en`: `fw_en=1`, `fw_sel=0`.
  - Else if `used & hitE & exu_load_en`: `fw_en=0`, because the younger load wins and `load_use` covers it.
  - Else if `used & hitL`: `fw_en=1`, `fw_sel=1`.
  - Otherwise `fw_en=0`.
- FSM states:
  - RUN, with priority `lsu_busy` > `taken` > `load_use`:
    - `lsu_busy`: `stall=1`, `flush_nop=0`, go MWAIT.
    - `taken`: `redirect=1`, `flush_nop=1`, `stall=0`; go RUN if `FLUSH_CYCLES==1`, else load `fcnt=FLUSH_CYCLES-2` and go FLUSH.
    - `load_use`: `stall=1`, `flush_nop=1`, go LU.
    - Otherwise no action.
  - LU: one cycle. `stall=0`, `flush_nop=0`; the load is now in LSU and `fw_sel=1` resolves the operand. Evaluate `lsu_busy` with RUN's rules, else go RUN.
  - FLUSH: `flush_nop=1`, `stall=0`, `taken` ignored. Go RUN when `fcnt==0`, else decrement `fcnt`. `lsu_busy` during FLUSH is ignored.
  - MWAIT: `stall=1`, `flush_nop=0` until `lsu_busy` falls, then back to RUN. `taken` and `load_use` are re-evaluated in RUN on the next cycle.
- Counters: each increments by 1 per cycle its output is high, wraps at 2^CNT_W, and has no saturation.

## Timing
- Reset: state=RUN, `fcnt=0`, `stall_cnt=flush_cnt=0`. `stall`, `flush_nop`, `redirect`, `fw_*` are forced 0 while `rst`=1. Asserting `rst` mid-FLUSH or mid-MWAIT abandons the sequence immediately.
- Control outputs are combinational from state plus current inputs, sampled by the stage registers at the following edge.
- Taken branch: exactly `FLUSH_CYCLES` consecutive cycles with `flush_nop=1`; `redirect` is high only in the first.
- Load-use: exactly one stall+bubble cycle per dependent pair.
- A taken branch and a load-use in the same cycle: taken wins, and no stall is issued.

## Test plan
- Back-to-back add x5 then add x6,x5,x0 -> `fw_en1=1`, `fw_sel1=0`, `stall=0`, no counter change.
- Load ld x7 followed by use of x7 as rs2 -> one cycle `stall=1`, `flush_nop=1`; next cycle `fw_en2=1`, `fw_sel2=1`; `stall_cnt=1`, `flush_cnt=1`.
- Taken branch with `FLUSH_CYCLES=2`; a second taken appears during FLUSH -> `redirect` one pulse, `flush_nop` high 2 cycles, second taken ignored, `flush_cnt=2`.
- `lsu_busy` held 4 cycles while `taken=1` -> `stall` 4 cycles; on release, `redirect` follows in RUN.
- rd=x0 in EXU matching rs1=0 -> `fw_en1=0`, no stall.
- `rst` pulsed in mid-FLUSH -> all outputs 0, counters 0, state RUN on the next edge.
